// File: rtl/alu_cmd_pkg.sv
// Shared opcodes, FSM encoding and constants for the ALU command-issue stage.
package alu_cmd_pkg;

    localparam logic [3:0] OP_ADD  = 4'd0;
    localparam logic [3:0] OP_SUB  = 4'd1;
    localparam logic [3:0] OP_MUL  = 4'd2;
    localparam logic [3:0] OP_DIV  = 4'd3;
    localparam logic [3:0] OP_MOD  = 4'd4;
    localparam logic [3:0] OP_LAND = 4'd5;
    localparam logic [3:0] OP_LOR  = 4'd6;
    localparam logic [3:0] OP_XOR  = 4'd7;
    localparam logic [3:0] OP_XNOR = 4'd8;
    localparam logic [3:0] OP_NAND = 4'd9;
    localparam logic [3:0] OP_NOR  = 4'd10;
    localparam logic [3:0] OP_NOTA = 4'd11;
    localparam logic [3:0] OP_NOTB = 4'd12;
    localparam logic [3:0] OP_SHL  = 4'd13;
    localparam logic [3:0] OP_LT   = 4'd14;
    localparam logic [3:0] OP_GT   = 4'd15;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        EXEC  = 2'd1,
        STALL = 2'd2
    } state_t;

    // Result substituted when the ALU is asked to divide or take modulo by zero.
    localparam logic [7:0] DZ_FILL = 8'hFF;

    function automatic logic is_divmod(input logic [3:0] op);
        return (op == OP_DIV) || (op == OP_MOD);
    endfunction

endpackage

// File: rtl/alu_cmd_fifo.sv
// Synchronous command FIFO; push is ignored when full, pop ignored when empty.
module alu_cmd_fifo #(
    parameter int DEPTH = 4,
    parameter int W     = 12
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   push,
    input  logic [W-1:0]           wdata,
    input  logic                   pop,
    output logic [W-1:0]           rdata,
    output logic                   full,
    output logic                   empty,
    output logic [$clog2(DEPTH):0] fill
);
    localparam int AW = $clog2(DEPTH);
    localparam int FW = AW + 1;

    logic [DEPTH-1:0][W-1:0] mem;
    logic [AW-1:0]           wr_ptr, rd_ptr;
    logic                    do_push, do_pop;

    assign full    = (fill == FW'(DEPTH));
    assign empty   = (fill == '0);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign rdata   = mem[rd_ptr];

    // Pointers are exactly AW bits wide, so wrap modulo DEPTH comes for free.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            fill   <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({do_push, do_pop})
                2'b10:   fill <= fill + 1'b1;
                2'b01:   fill <= fill - 1'b1;
                default: fill <= fill;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= wdata;
    end

endmodule

// File: rtl/alu_cmd_issue.sv
// Command-issue stage: FIFO -> issue register (drives ALU) -> result register with valid/ready.
module alu_cmd_issue
    import alu_cmd_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int DW    = 4,
    parameter int OW    = 8
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   cmd_valid,
    output logic                   cmd_ready,
    input  logic [3:0]             cmd_op,
    input  logic [DW-1:0]          cmd_a,
    input  logic [DW-1:0]          cmd_b,
    output logic                   alu_en,
    output logic [3:0]             alu_op,
    output logic [DW-1:0]          alu_a,
    output logic [DW-1:0]          alu_b,
    input  logic [OW-1:0]          alu_out,
    output logic                   res_valid,
    input  logic                   res_ready,
    output logic [OW-1:0]          res_data,
    output logic [3:0]             res_op,
    output logic                   res_dz,
    output logic [$clog2(DEPTH):0] fill
);
    localparam int CW = 4 + 2 * DW;

    state_t        state, state_n;
    logic          pop, capture, slot_free, dz;
    logic          fifo_full, fifo_empty;
    logic [CW-1:0] head;

    alu_cmd_fifo #(.DEPTH(DEPTH), .W(CW)) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (cmd_valid && cmd_ready),
        .wdata ({cmd_op, cmd_a, cmd_b}),
        .pop   (pop),
        .rdata (head),
        .full  (fifo_full),
        .empty (fifo_empty),
        .fill  (fill)
    );

    // Full is a pure function of fill, so a same-cycle pop never frees a slot.
    assign cmd_ready = !fifo_full;
    assign slot_free = !res_valid || res_ready;
    assign dz        = is_divmod(alu_op) && (alu_b == '0);

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_n;
    end

    always_comb begin
        state_n = state;
        pop     = 1'b0;
        capture = 1'b0;
        alu_en  = 1'b0;
        case (state)
            IDLE: begin
                if (!fifo_empty) begin
                    pop     = 1'b1;
                    state_n = EXEC;
                end
            end
            EXEC, STALL: begin
                alu_en = 1'b1;
                if (slot_free) begin
                    capture = 1'b1;
                    pop     = !fifo_empty;
                    state_n = fifo_empty ? IDLE : EXEC;
                end else begin
                    state_n = STALL;
                end
            end
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            alu_op <= '0;
            alu_a  <= '0;
            alu_b  <= '0;
        end else if (pop) begin
            {alu_op, alu_a, alu_b} <= head;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            res_valid <= 1'b0;
            res_data  <= '0;
            res_op    <= '0;
            res_dz    <= 1'b0;
        end else if (capture) begin
            res_valid <= 1'b1;
            res_data  <= dz ? OW'(DZ_FILL) : alu_out;
            res_op    <= alu_op;
            res_dz    <= dz;
        end else if (res_ready) begin
            res_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_alu_cmd_issue.sv
// Self-checking bench for alu_cmd_issue: directed vectors, stall/reset sequences, random traffic.
module tb_alu_cmd_issue;

    logic       clk = 1'b0;
    logic       rst;
    logic       cmd_valid, cmd_ready;
    logic [3:0] cmd_op, cmd_a, cmd_b;
    logic       alu_en;
    logic [3:0] alu_op, alu_a, alu_b;
    logic [7:0] alu_out;
    logic       res_valid, res_ready;
    logic [7:0] res_data;
    logic [3:0] res_op;
    logic       res_dz;
    logic [2:0] fill;

    alu_cmd_issue #(.DEPTH(4), .DW(4), .OW(8)) dut (
        .clk(clk), .rst(rst),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_op(cmd_op), .cmd_a(cmd_a), .cmd_b(cmd_b),
        .alu_en(alu_en), .alu_op(alu_op), .alu_a(alu_a), .alu_b(alu_b),
        .alu_out(alu_out),
        .res_valid(res_valid), .res_ready(res_ready),
        .res_data(res_data), .res_op(res_op), .res_dz(res_dz),
        .fill(fill)
    );

    always #5 clk = ~clk;

    // Stand-in 4-bit ALU; div/mod by zero return junk the DUT must override.
    function automatic logic [7:0] alu_f(input logic [3:0] op, input logic [3:0] a, input logic [3:0] b);
        logic [7:0] ea, eb;
        ea = {4'b0, a};
        eb = {4'b0, b};
        case (op)
            4'd0:  return ea + eb;
            4'd1:  return ea - eb;
            4'd2:  return ea * eb;
            4'd3:  return (b != 0) ? ea / eb : 8'h5A;
            4'd4:  return (b != 0) ? ea % eb : 8'hA5;
            4'd5:  return {7'b0, (a != 0) && (b != 0)};
            4'd6:  return {7'b0, (a != 0) || (b != 0)};
            4'd7:  return {4'b0, a ^ b};
            4'd8:  return {4'b0, ~(a ^ b)};
            4'd9:  return {4'b0, ~(a & b)};
            4'd10: return {4'b0, ~(a | b)};
            4'd11: return {4'b0, ~a};
            4'd12: return {4'b0, ~b};
            4'd13: return ea << b;
            4'd14: return {7'b0, a < b};
            default: return {7'b0, a > b};
        endcase
    endfunction

    assign alu_out = alu_f(alu_op, alu_a, alu_b);

    typedef struct {
        logic [3:0] op;
        logic [7:0] data;
        logic       dz;
    } res_t;

    function automatic res_t model(input logic [3:0] op, input logic [3:0] a, input logic [3:0] b);
        res_t r;
        r.op = op;
        r.dz = (op == 4'd3 || op == 4'd4) && (b == 0);
        r.data = r.dz ? 8'hFF : alu_f(op, a, b);
        return r;
    endfunction

    int tests = 0;
    int fails = 0;
    int res_cnt = 0;
    res_t q[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Mid-cycle monitor: scoreboard on both handshakes plus hold stability.
    logic       hold_v = 1'b0;
    logic [7:0] hold_d;
    logic [3:0] hold_o;
    logic       hold_z;
    always @(negedge clk) begin
        if (rst) begin
            q.delete();
            hold_v = 1'b0;
        end else begin
            chk("cmd_ready_rule", 32'(cmd_ready), 32'(fill < 3'd4));
            if (hold_v && res_valid) begin
                chk("hold_data", 32'(res_data), 32'(hold_d));
                chk("hold_op", 32'(res_op), 32'(hold_o));
                chk("hold_dz", 32'(res_dz), 32'(hold_z));
            end
            if (res_valid && res_ready) begin
                res_t e;
                res_cnt++;
                if (q.size() == 0) begin
                    chk("res_unexpected", 32'(res_valid), 0);
                end else begin
                    e = q.pop_front();
                    chk("sb_data", 32'(res_data), 32'(e.data));
                    chk("sb_op", 32'(res_op), 32'(e.op));
                    chk("sb_dz", 32'(res_dz), 32'(e.dz));
                end
            end
            if (cmd_valid && cmd_ready) q.push_back(model(cmd_op, cmd_a, cmd_b));
            hold_v = res_valid && !res_ready;
            hold_d = res_data;
            hold_o = res_op;
            hold_z = res_dz;
        end
    end

    typedef struct {
        logic [3:0] op, a, b;
        logic [7:0] data;
        logic       dz;
    } vec_t;
    vec_t vecs[10];

    initial begin
        int sent, base, k;
        vecs[0] = '{4'd0,  4'd7,  4'd9, 8'd16,  1'b0};
        vecs[1] = '{4'd3,  4'd12, 4'd0, 8'hFF,  1'b1};
        vecs[2] = '{4'd4,  4'd5,  4'd0, 8'hFF,  1'b1};
        vecs[3] = '{4'd3,  4'd12, 4'd5, 8'd2,   1'b0};
        vecs[4] = '{4'd1,  4'd3,  4'd5, 8'hFE,  1'b0};
        vecs[5] = '{4'd2,  4'd15, 4'd15, 8'd225, 1'b0};
        vecs[6] = '{4'd7,  4'd5,  4'd3, 8'd6,   1'b0};
        vecs[7] = '{4'd13, 4'd1,  4'd3, 8'd8,   1'b0};
        vecs[8] = '{4'd14, 4'd2,  4'd9, 8'd1,   1'b0};
        vecs[9] = '{4'd4,  4'd7,  4'd3, 8'd1,   1'b0};

        rst = 1'b1; cmd_valid = 1'b0; cmd_op = '0; cmd_a = '0; cmd_b = '0; res_ready = 1'b1;
        repeat (2) step();
        chk("rst_fill", 32'(fill), 0);
        chk("rst_alu_en", 32'(alu_en), 0);
        chk("rst_alu_op", 32'(alu_op), 0);
        chk("rst_alu_ab", 32'({alu_a, alu_b}), 0);
        chk("rst_res_valid", 32'(res_valid), 0);
        chk("rst_res_data", 32'(res_data), 0);
        chk("rst_res_op_dz", 32'({res_op, res_dz}), 0);
        chk("rst_cmd_ready", 32'(cmd_ready), 1);
        rst = 1'b0;
        step();

        // Single commands into an idle block: latency and result value.
        foreach (vecs[i]) begin
            cmd_valid = 1'b1; cmd_op = vecs[i].op; cmd_a = vecs[i].a; cmd_b = vecs[i].b;
            step();
            cmd_valid = 1'b0;
            chk("lat0_fill", 32'(fill), 1);
            chk("lat0_alu_en", 32'(alu_en), 0);
            step();
            chk("lat1_alu_en", 32'(alu_en), 1);
            chk("lat1_res_valid", 32'(res_valid), 0);
            step();
            chk("lat2_res_valid", 32'(res_valid), 1);
            chk("vec_data", 32'(res_data), 32'(vecs[i].data));
            chk("vec_op", 32'(res_op), 32'(vecs[i].op));
            chk("vec_dz", 32'(res_dz), 32'(vecs[i].dz));
            step();
            step();
        end

        // Backpressure: 6 commands with res_ready low.
        res_ready = 1'b0;
        sent = 0;
        for (int c = 0; c < 30 && sent < 6; c++) begin
            if (cmd_ready) begin
                cmd_valid = 1'b1; cmd_op = 4'd0; cmd_a = 4'(sent); cmd_b = 4'(sent + 1);
                sent++;
            end else begin
                cmd_valid = 1'b0;
            end
            step();
        end
        cmd_valid = 1'b0;
        chk("stall_sent", 32'(sent), 6);
        chk("stall_fill", 32'(fill), 4);
        chk("stall_cmd_ready", 32'(cmd_ready), 0);
        chk("stall_alu_en", 32'(alu_en), 1);
        chk("stall_res_valid", 32'(res_valid), 1);
        chk("stall_res_data", 32'(res_data), 1);
        repeat (3) step();
        chk("stall_res_data_hold", 32'(res_data), 1);
        chk("stall_alu_a_hold", 32'(alu_a), 1);
        base = res_cnt;
        res_ready = 1'b1;
        for (int c = 0; c < 20 && res_cnt < base + 6; c++) step();
        chk("stall_drain_cnt", 32'(res_cnt - base), 6);
        repeat (3) step();

        // Back-to-back stream, one result per cycle, pointers wrap.
        for (k = 0; k < 18; k++) begin
            cmd_valid = (k < 16); cmd_op = 4'd2; cmd_a = 4'(k); cmd_b = 4'd3;
            step();
            if (k >= 2) begin
                chk("stream_valid", 32'(res_valid), 1);
                chk("stream_data", 32'(res_data), 32'(3 * (k - 2)));
            end
        end
        cmd_valid = 1'b0;
        repeat (3) step();

        // Reset while stalled with three commands queued.
        res_ready = 1'b0;
        sent = 0;
        for (int c = 0; c < 30 && sent < 5; c++) begin
            cmd_valid = 1'b1; cmd_op = 4'd7; cmd_a = 4'(sent); cmd_b = 4'd9;
            sent++;
            step();
        end
        cmd_valid = 1'b0;
        chk("pre_rst_fill", 32'(fill), 3);
        chk("pre_rst_alu_en", 32'(alu_en), 1);
        rst = 1'b1;
        step();
        rst = 1'b0;
        chk("mid_rst_res_valid", 32'(res_valid), 0);
        chk("mid_rst_alu_en", 32'(alu_en), 0);
        chk("mid_rst_fill", 32'(fill), 0);
        chk("mid_rst_cmd_ready", 32'(cmd_ready), 1);
        res_ready = 1'b1;
        base = res_cnt;
        repeat (10) step();
        chk("post_rst_no_stale", 32'(res_cnt - base), 0);

        // Random traffic with random backpressure.
        for (int c = 0; c < 200; c++) begin
            cmd_valid = 1'($urandom_range(0, 1));
            cmd_op    = 4'($urandom_range(0, 15));
            cmd_a     = 4'($urandom_range(0, 15));
            cmd_b     = ($urandom_range(0, 3) == 0) ? 4'd0 : 4'($urandom_range(0, 15));
            res_ready = 1'($urandom_range(0, 1));
            step();
        end
        cmd_valid = 1'b0;
        res_ready = 1'b1;
        for (int c = 0; c < 50 && (q.size() != 0 || res_valid); c++) step();
        chk("rand_drain_empty", 32'(q.size()), 0);
        chk("rand_final_fill", 32'(fill), 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
